lshifter32_seq: RTL and testbench

- Multi-cycle sequential 32-bit logical left shifter; the left-shift counterpart to the ALU32 combinational right shifter.
- Shifts In1 left by In2[4:0] bit positions, at most STEP positions per clock.
- Valid/ready handshake on input and output, so the ALU32 control FSM can stall on it.
- Built for area-constrained ALU32 variants where a full barrel shifter is too costly.

---
 rtl/lshifter32_pkg.sv | 23 ++
 rtl/lshift_step.sv | 26 ++
 rtl/lshifter32_seq.sv | 121 ++++++++++++
 tb/tb_lshifter32_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lshifter32_pkg.sv
// Shared types, state encoding and helpers for the sequential 32-bit left shifter.
package lshifter32_pkg;

  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned WIDTH_DEF = 32;

  typedef logic [SHAMT_W-1:0] shamt_t;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Positions to shift this cycle: min(step, rem).
  function automatic shamt_t step_amount(input shamt_t rem, input int unsigned step);
    logic [31:0] rem_ext;
    rem_ext = {27'd0, rem};
    if (rem_ext < step) begin
      return rem;
    end
    return shamt_t'(step);
  endfunction

endpackage

// File: rtl/lshift_step.sv
// One iteration of the shifter: data << min(STEP, rem), remaining count, and the bits pushed out.
module lshift_step
  import lshifter32_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [31:0] data_i,
  input  shamt_t      rem_i,
  output logic [31:0] data_o,
  output shamt_t      rem_o,
  output logic [7:0]  shout_o
);

  shamt_t      k;
  logic [63:0] wide;

  always_comb begin
    k       = step_amount(rem_i, STEP);
    // Upper half collects whatever leaves bit 31; at most 8 bits per step.
    wide    = {32'd0, data_i} << k;
    data_o  = wide[31:0];
    rem_o   = rem_i - k;
    shout_o = wide[39:32];
  end

endmodule

// File: rtl/lshifter32_seq.sv
// Multi-cycle 32-bit logical left shifter with valid/ready handshakes on both sides.
// Optional sticky overflow output Ovf is compiled in with LSHIFTER32_SEQ_OVF_EN.
module lshifter32_seq
  import lshifter32_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy
`ifdef LSHIFTER32_SEQ_OVF_EN
  ,
  output logic             Ovf
`endif
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  shamt_t           rem_q, rem_d;

  logic [31:0] step_data;
  shamt_t      step_rem;
  logic [7:0]  step_shout;

  // Only the low bits of the shift amount matter; 32 wraps to 0.
  logic unused_in2_hi;
  assign unused_in2_hi = ^In2[WIDTH-1:SHAMT_W];

  lshift_step #(
    .STEP (STEP)
  ) u_step (
    .data_i  (out_q),
    .rem_i   (rem_q),
    .data_o  (step_data),
    .rem_o   (step_rem),
    .shout_o (step_shout)
  );

`ifdef LSHIFTER32_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic [7:0] unused_shout;
  assign unused_shout = step_shout;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
`ifdef LSHIFTER32_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (InValid) begin
          out_d   = In1;
          rem_d   = In2[SHAMT_W-1:0];
          state_d = StShift;
`ifdef LSHIFTER32_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          out_d = step_data;
          rem_d = step_rem;
`ifdef LSHIFTER32_SEQ_OVF_EN
          ovf_d = ovf_q | (|step_shout);
`endif
        end
      end
      StDone: begin
        if (OutReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= '0;
      rem_q   <= '0;
`ifdef LSHIFTER32_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
`ifdef LSHIFTER32_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    InReady  = (state_q == StIdle);
    OutValid = (state_q == StDone);
    Busy     = (state_q == StShift) || (state_q == StDone);
    Out      = out_q;
  end

`ifdef LSHIFTER32_SEQ_OVF_EN
  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_lshifter32_seq.sv
// Bench for lshifter32_seq: four instances (STEP 1, 2, 4, 8) driven in lockstep.
module tb_lshifter32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic [31:0] out_w       [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        busy_w      [4];
`ifdef LSHIFTER32_SEQ_OVF_EN
  logic        ovf_w       [4];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lshifter32_seq #(
      .WIDTH (32),
      .STEP  (1 << g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .In1      (in1),
      .In2      (in2),
      .InValid  (in_valid),
      .InReady  (in_ready_w[g]),
      .Out      (out_w[g]),
      .OutValid (out_valid_w[g]),
      .OutReady (out_ready),
      .Busy     (busy_w[g])
`ifdef LSHIFTER32_SEQ_OVF_EN
      ,
      .Ovf      (ovf_w[g])
`endif
    );
  end

  function automatic int exp_lat(input logic [31:0] b, input int lane);
    int sh;
    int st;
    sh = int'(b[4:0]);
    st = 1 << lane;
    return (sh + st - 1) / st + 1;
  endfunction

  task automatic check_idle_outputs(input string name);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s lane%0d: OutValid/InReady/Busy got %b%b%b want 010", name, i,
                 out_valid_w[i], in_ready_w[i], busy_w[i]);
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready_w[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL issue_ready lane%0d: got %b want 1", i, in_ready_w[i]);
      end
    end
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for OutValid on every lane; the first pulse_cycles cycles drive junk InValid.
  task automatic wait_done(input int pulse_cycles);
    int cyc;
    bit all;
    cyc = 0;
    all = 1'b0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    while (!all && cyc < 40) begin
      if (cyc < pulse_cycles) begin
        in_valid = 1'b1;
        in1      = 32'hFFFF_FFFF;
        in2      = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (out_valid_w[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
        if (lat[i] == 0) all = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!all) begin
      n_fail++;
      $display("FAIL timeout: OutValid missing after %0d cycles, want all lanes valid", cyc);
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
`ifdef LSHIFTER32_SEQ_OVF_EN
    logic [63:0] w;
    logic        exp_ovf;
    w       = {32'd0, a} << b[4:0];
    exp_ovf = |w[63:32];
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_w[i] !== exp) begin
        n_fail++;
        $display("FAIL %s out lane%0d: got %h want %h", name, i, out_w[i], exp);
      end
      n_checks++;
      if (lat[i] != exp_lat(b, i)) begin
        n_fail++;
        $display("FAIL %s latency lane%0d: got %0d want %0d", name, i, lat[i], exp_lat(b, i));
      end
`ifdef LSHIFTER32_SEQ_OVF_EN
      n_checks++;
      if (ovf_w[i] !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s ovf lane%0d: got %b want %b", name, i, ovf_w[i], exp_ovf);
      end
`endif
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_idle_outputs(name);
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    issue(a, b);
    wait_done(0);
    check_result(name, a, b, exp);
    release_out(name);
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_w[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_out lane%0d: got %h want 00000000", i, out_w[i]);
      end
    end
    check_idle_outputs("reset_flags");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_op("basic", 32'h0000_0001, 32'd4, 32'h0000_0010);
  endtask

  task automatic test_zero_shift();
    do_op("zero", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    do_op("zero_in2_32", 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
  endtask

  task automatic test_max_shift();
    do_op("max31", 32'hFFFF_FFFF, 32'd31, 32'h8000_0000);
  endtask

  task automatic test_vectors();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] ve [10];
    va[0] = 32'h1234_5678; vb[0] = 32'd8;          ve[0] = 32'h3456_7800;
    va[1] = 32'h1234_5678; vb[1] = 32'd4;          ve[1] = 32'h2345_6780;
    va[2] = 32'h8000_0001; vb[2] = 32'd1;          ve[2] = 32'h0000_0002;
    va[3] = 32'hA5A5_A5A5; vb[3] = 32'd16;         ve[3] = 32'hA5A5_0000;
    va[4] = 32'h0000_FFFF; vb[4] = 32'd12;         ve[4] = 32'h0FFF_F000;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFE5;  ve[5] = 32'hFFFF_FFE0;
    va[6] = 32'h0000_0003; vb[6] = 32'd7;          ve[6] = 32'h0000_0180;
    va[7] = 32'h1234_5678; vb[7] = 32'd31;         ve[7] = 32'h0000_0000;
    va[8] = 32'h0000_0001; vb[8] = 32'd31;         ve[8] = 32'h8000_0000;
    va[9] = 32'h0F0F_0F0F; vb[9] = 32'd3;          ve[9] = 32'h7878_7878;
    for (int v = 0; v < 10; v++) begin
      do_op($sformatf("vec%0d", v), va[v], vb[v], ve[v]);
    end
  endtask

  task automatic test_backpressure();
    issue(32'h0000_0005, 32'd3);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_shift lane%0d: Busy/InReady got %b%b want 10", i, busy_w[i],
                 in_ready_w[i]);
      end
    end
    wait_done(2);
    check_result("bp", 32'h0000_0005, 32'd3, 32'h0000_0028);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_w[i] !== 32'h0000_0028 || out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0
            || busy_w[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold c%0d lane%0d: out %h OutValid/InReady/Busy %b%b%b want 00000028 101",
                   c, i, out_w[i], out_valid_w[i], in_ready_w[i], busy_w[i]);
        end
      end
    end
    release_out("bp_release");
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0009, 32'd2);
    wait_done(0);
    check_result("b2b_first", 32'h0000_0009, 32'd2, 32'h0000_0024);
    // New operands offered in the same cycle as the DONE handshake.
    in1       = 32'h0000_00F0;
    in2       = 32'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_idle_outputs("b2b_not_accepted");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready_w[i] !== 1'b0 || busy_w[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_accept lane%0d: InReady/Busy got %b%b want 01", i, in_ready_w[i],
                 busy_w[i]);
      end
    end
    wait_done(0);
    check_result("b2b_second", 32'h0000_00F0, 32'd5, 32'h0000_1E00);
    release_out("b2b_release");
  endtask

  task automatic test_reset_mid();
    issue(32'h1234_5678, 32'd20);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_w[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL midreset_out lane%0d: got %h want 00000000", i, out_w[i]);
      end
    end
    check_idle_outputs("midreset_flags");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_reset", 32'h0000_0003, 32'd1, 32'h0000_0006);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_shift();
    test_max_shift();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
